// File: rtl/quotient_window_accumulator_pkg.sv
// Purpose: shared fixed-point constants, saturation bounds and FSM state type for the quotient path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package quotient_window_accumulator_pkg;

  localparam int FRAC_BITS = 12;
  localparam logic [31:0] FIX_ONE = 32'h00001000;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Largest value representable in an n-bit signed field (n <= 64).
  function automatic logic signed [63:0] sat_max(input int n);
    logic signed [63:0] one;
    one = 64'sd1;
    return (one <<< (n - 1)) - one;
  endfunction

  // Smallest value representable in an n-bit signed field (n <= 64).
  function automatic logic signed [63:0] sat_min(input int n);
    logic signed [63:0] one;
    one = 64'sd1;
    return -(one <<< (n - 1));
  endfunction

endpackage

// File: rtl/quotient_window_accumulator_if.sv
// Purpose: sample-in / window-result-out handshake bundle for the quotient window accumulator.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the sample side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, in_data, flush (sample side); out_valid, out_ready, out_sum,
//        out_mean, out_count, out_sat (result side). master = producer/consumer, slave = block.
interface quotient_window_accumulator_if #(
  parameter int N        = 32,
  parameter int LOG2_LEN = 3
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_sum;
  logic signed [N-1:0] out_mean;
  logic [LOG2_LEN:0]   out_count;
  logic                out_sat;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_mean, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_mean, out_count, out_sat
  );
endinterface

// File: rtl/quotient_window_accumulator_sat_narrow.sv
// Purpose: signed saturating narrower from IN_W to OUT_W bits with an overflow flag.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its input).
// Ports: in_val (IN_W signed), out_val (OUT_W signed, clipped), ovf (1 when clipping happened).
module sat_narrow
  import quotient_window_accumulator_pkg::*;
#(
  parameter int IN_W  = 35,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    ovf
);

  localparam logic signed [63:0] HI = sat_max(OUT_W);
  localparam logic signed [63:0] LO = sat_min(OUT_W);

  logic signed [63:0] wide;

  always_comb begin
    // Size cast of a signed operand sign-extends, so comparisons are done in 64-bit signed space.
    wide    = 64'(in_val);
    out_val = wide[OUT_W-1:0];
    ovf     = 1'b0;
    if (wide > HI) begin
      out_val = HI[OUT_W-1:0];
      ovf     = 1'b1;
    end else if (wide < LO) begin
      out_val = LO[OUT_W-1:0];
      ovf     = 1'b1;
    end
  end

endmodule

// File: rtl/quotient_window_accumulator.sv
// Purpose: accumulate signed Q(N-13).12 quotient samples over 2^LOG2_LEN-sample windows (flush closes early).
// Latency: result registered; out_valid high the cycle after the closing sample/flush is taken.
// Backpressure: in_ready drops while a result is held; result held stable until out_ready.
// Ports: clk, rst (async, active-high), bus (slave modport: in_valid/in_ready/in_data/flush,
//        out_valid/out_ready/out_sum/out_mean/out_count/out_sat).
module quotient_window_accumulator
  import quotient_window_accumulator_pkg::*;
#(
  parameter int N        = 32,
  parameter int LOG2_LEN = 3
) (
  input logic                          clk,
  input logic                          rst,
  quotient_window_accumulator_if.slave bus
);

  localparam int ACC_W = N + LOG2_LEN;
  localparam logic [LOG2_LEN:0] CNT_FULL = {1'b1, {LOG2_LEN{1'b0}}};
  localparam logic [LOG2_LEN:0] CNT_ONE  = {{LOG2_LEN{1'b0}}, 1'b1};

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_upd;
  logic signed [ACC_W-1:0] mean_wide;
  logic [LOG2_LEN:0]       cnt;
  logic [LOG2_LEN:0]       cnt_upd;
  logic                    accept;
  logic                    close_win;

  logic                    in_ready_q;
  logic                    out_valid_q;
  logic signed [N-1:0]     sum_q;
  logic signed [N-1:0]     mean_q;
  logic [LOG2_LEN:0]       count_q;
  logic                    sat_q;

  logic signed [N-1:0]     sum_clip;
  logic signed [N-1:0]     mean_clip;
  logic                    sum_ovf;
  logic                    mean_ovf;

  // Post-update view of the window: the captured result must include a sample
  // accepted in the same cycle as the closing condition.
  always_comb begin
    accept  = (state == ACC) && in_ready_q && bus.in_valid;
    acc_upd = acc;
    cnt_upd = cnt;
    if (accept) begin
      acc_upd = acc + {{LOG2_LEN{bus.in_data[N-1]}}, bus.in_data};
      cnt_upd = cnt + CNT_ONE;
    end
    // A flush on an empty window is dropped rather than producing an empty result.
    close_win = (state == ACC) &&
                ((accept && (cnt_upd == CNT_FULL)) || (bus.flush && (cnt_upd != '0)));
    // Arithmetic shift: partial windows divide as if zero-padded, rounding toward -inf.
    mean_wide = acc_upd >>> LOG2_LEN;
  end

  sat_narrow #(.IN_W(ACC_W), .OUT_W(N)) u_sum_narrow (
    .in_val  (acc_upd),
    .out_val (sum_clip),
    .ovf     (sum_ovf)
  );

  sat_narrow #(.IN_W(ACC_W), .OUT_W(N)) u_mean_narrow (
    .in_val  (mean_wide),
    .out_val (mean_clip),
    .ovf     (mean_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      mean_q      <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          // in_ready comes up on the first edge after reset release.
          in_ready_q <= 1'b1;
          acc        <= acc_upd;
          cnt        <= cnt_upd;
          if (close_win) begin
            state       <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            sum_q       <= sum_clip;
            mean_q      <= mean_clip;
            count_q     <= cnt_upd;
            // The mean can only clip when the sum does, so this is the sum-clip flag.
            sat_q       <= sum_ovf | mean_ovf;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACC;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state <= ACC;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_mean  = mean_q;
  assign bus.out_count = count_q;
  assign bus.out_sat   = sat_q;

endmodule
